// File: rtl/debug_uart_baud_gen.sv
// Fractional-divisor baud generator for the debug UART: oversample tick,
// mid-bit and end-of-bit ticks, bit-rate square wave, runtime divisor reload.
module debug_uart_baud_gen #(
    parameter int unsigned CLOCK_FREQ = 40000000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FRAC_BITS  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 restart,
    input  logic                 cfg_load,
    input  logic [CNT_WIDTH-1:0] cfg_div_int,
    input  logic [FRAC_BITS-1:0] cfg_div_frac,
    output logic                 os_tick,
    output logic                 mid_tick,
    output logic                 bit_tick,
    output logic                 clk_out,
    output logic                 cfg_err
);

    localparam int unsigned OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [63:0] DIV_FULL =
        (64'(CLOCK_FREQ) << FRAC_BITS) / (64'(BAUDRATE) * 64'(OVERSAMPLE));
    localparam logic [CNT_WIDTH-1:0] DIV_INT_RST  = CNT_WIDTH'(DIV_FULL >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DIV_FRAC_RST = FRAC_BITS'(DIV_FULL);

    logic [CNT_WIDTH-1:0] cnt;
    logic [FRAC_BITS-1:0] acc;
    logic                 ext;
    logic [OS_W-1:0]      os_cnt;
    logic [CNT_WIDTH-1:0] div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic [CNT_WIDTH-1:0] shadow_int;
    logic [FRAC_BITS-1:0] shadow_frac;
    logic                 pend;

    logic                 valid_load_c;
    logic                 last_c;
    logic                 tick_c;
    logic                 os_mid_c;
    logic                 os_last_c;
    logic [FRAC_BITS:0]   acc_sum_c;

    // Interval end is cnt == div_int + ext - 1, written to avoid wrap on the add.
    always_comb begin
        valid_load_c = cfg_load && (cfg_div_int >= CNT_WIDTH'(2));
        last_c       = ext ? (cnt == div_int) : (cnt == div_int - CNT_WIDTH'(1));
        tick_c       = enable && !restart && last_c;
        os_mid_c     = (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
        os_last_c    = (os_cnt == OS_W'(OVERSAMPLE - 1));
        acc_sum_c    = {1'b0, acc} + {1'b0, div_frac};
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            ext         <= 1'b0;
            os_cnt      <= '0;
            div_int     <= DIV_INT_RST;
            div_frac    <= DIV_FRAC_RST;
            shadow_int  <= DIV_INT_RST;
            shadow_frac <= DIV_FRAC_RST;
            pend        <= 1'b0;
            os_tick     <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
            clk_out     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            os_tick  <= tick_c;
            mid_tick <= tick_c && os_mid_c;
            bit_tick <= tick_c && os_last_c;
            cfg_err  <= cfg_load && !valid_load_c;

            if (valid_load_c) begin
                shadow_int  <= cfg_div_int;
                shadow_frac <= cfg_div_frac;
            end

            if (restart) begin
                // Phase realign; any new or pending divisor goes active now.
                cnt     <= '0;
                acc     <= '0;
                ext     <= 1'b0;
                os_cnt  <= '0;
                clk_out <= 1'b0;
                pend    <= 1'b0;
                if (valid_load_c) begin
                    div_int  <= cfg_div_int;
                    div_frac <= cfg_div_frac;
                end else if (pend) begin
                    div_int  <= shadow_int;
                    div_frac <= shadow_frac;
                end
            end else begin
                if (tick_c) begin
                    cnt    <= '0;
                    acc    <= acc_sum_c[FRAC_BITS-1:0];
                    ext    <= acc_sum_c[FRAC_BITS];
                    os_cnt <= os_last_c ? '0 : os_cnt + OS_W'(1);
                    if (os_mid_c) begin
                        clk_out <= 1'b1;
                    end else if (os_last_c) begin
                        clk_out <= 1'b0;
                    end
                    if (pend) begin
                        div_int  <= shadow_int;
                        div_frac <= shadow_frac;
                    end
                end else if (enable) begin
                    cnt <= cnt + CNT_WIDTH'(1);
                end

                // A load coinciding with the boundary re-arms for the next one.
                if (valid_load_c) begin
                    pend <= 1'b1;
                end else if (tick_c) begin
                    pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/debug_uart_baud_gen.md
# debug_uart_baud_gen

Parametrised, runtime-programmable baud-rate generator for the debug UART, replacing the fixed integer divider. It derives an oversampling tick from `clk_in` through a fractional (integer + FRAC_BITS) divisor, counts OVERSAMPLE sub-ticks per bit, and provides bit, mid-bit and square-wave outputs to the UART TX/RX engines. It supports enable/hold, phase restart for RX start-bit alignment, and glitch-free divisor reload.

## Interface
- `CLOCK_FREQ`, 40000000: input clock frequency in Hz.
- `BAUDRATE`, 115200: reset-time baud rate.
- `OVERSAMPLE`, 16: sub-ticks per bit. Must be even and ≥ 2.
- `FRAC_BITS`, 4: fractional divisor bits.
- `CNT_WIDTH`, 16: integer divisor and counter width.
- `clk_in` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: when high, the generator runs; when low, all state holds.
- `restart` input 1: one-cycle pulse that realigns phase to the start of a bit.
- `cfg_load` input 1: one-cycle strobe that loads a new divisor.
- `cfg_div_int` input CNT_WIDTH: integer part of the oversample interval, in clk_in cycles.
- `cfg_div_frac` input FRAC_BITS: fractional part, in units of 2^-FRAC_BITS.
- `os_tick` output 1: one-cycle pulse per oversample interval.
- `mid_tick` output 1: one-cycle pulse at the mid-bit sampling point.
- `bit_tick` output 1: one-cycle pulse at the end of each bit.
- `clk_out` output 1: bit-rate square wave.
- `cfg_err` output 1: one-cycle pulse when a `cfg_load` is rejected.

## Operation
- **Reset divisor:** D = CLOCK_FREQ·2^FRAC_BITS / (BAUDRATE·OVERSAMPLE), truncated. DIV_INT = D >> FRAC_BITS; DIV_FRAC = D mod 2^FRAC_BITS. Defaults give 347, i.e. 21 + 11/16.
- **State:**
  - interval counter `cnt`, CNT_WIDTH bits;
  - fraction accumulator `acc`, FRAC_BITS bits;
  - `ext` flag, which makes the current interval 1 cycle longer;
  - sub-tick counter `os_cnt`, 0..OVERSAMPLE-1;
  - active divisor (`div_int`, `div_frac`);
  - shadow divisor with a `pend` flag.
- **Interval:** current length L = div_int + ext. With enable high, `cnt` increments each cycle. When cnt = L-1, the block does all of the following in the same cycle:
  - asserts os_tick;
  - clears cnt;
  - sets {carry, acc} = acc + div_frac;
  - sets ext = carry;
  - if pend is set, copies the shadow divisor into the active divisor and clears pend.
- **Sub-ticks:** on each os_tick, os_cnt wraps at OVERSAMPLE-1.
  - mid_tick = os_tick & (os_cnt == OVERSAMPLE/2-1).
  - bit_tick = os_tick & (os_cnt == OVERSAMPLE-1).
- **clk_out:** set to 1 on mid_tick, cleared to 0 on bit_tick.
- **cfg_load:**
  - If cfg_div_int < 2: pulse cfg_err and leave shadow and pend unchanged.
  - Otherwise: capture the value into the shadow and set pend. A second valid load before the boundary overwrites the shadow (last wins).
- **restart:** overrides enable and sets cnt=0, acc=0, ext=0, os_cnt=0, clk_out=0. Any pending shadow is applied immediately. A valid cfg_load in the same cycle is applied directly as the active divisor, and pend is left clear.
- **enable low:** cnt, acc, os_cnt and clk_out hold. No ticks are produced. cfg_load and restart are still serviced.
- **Reset:** cnt=0, acc=0, ext=0, os_cnt=0, pend=0, active divisor = defaults. os_tick, mid_tick, bit_tick, clk_out and cfg_err are all 0.

## Timing
- All outputs are registered. Each tick is high for exactly one clk_in cycle.
- The first os_tick occurs DIV_INT cycles after the first enabled edge following reset release or restart.
- Interval length is L or L+1 exactly, with no jitter beyond 1 cycle. Over 2^FRAC_BITS ticks, the steady-state average equals div_int + div_frac/2^FRAC_BITS.
- A new divisor never truncates an interval in progress. It takes effect from the interval after the next os_tick.
- cfg_err is asserted in the cycle after the rejected cfg_load.
- restart is effective on the edge where it is sampled; os_tick cannot occur in that cycle.

## Test plan
- **Defaults, enable held high:** os_tick at cycles 21, 42 and 64 (interval 22 after the first carry). Spacing between bit_tick #1 and bit_tick #2 is exactly 347 cycles.
- **cfg_load int=4, frac=0 issued mid-interval:** the current interval completes at its old length. All following os_ticks are 4 cycles apart, and bit_tick spacing is 64 cycles.
- **cfg_load int=1:** cfg_err pulses once and tick spacing is unchanged. Repeat with int=0.
- **restart at os_cnt=9 with int=4, frac=8:** clk_out goes to 0 immediately. The next mid_tick comes 8 os_ticks later, with intervals alternating 4 and 5 cycles.
- **enable low for 50 cycles mid-interval:** no ticks during the gap, and after re-enable the interval resumes from the held cnt. Then assert reset asynchronously between edges: all outputs go to 0 at once, and the default divisor is restored.
